rvfi_commit_tracker: RTL and testbench
======================================

Name: rvfi_commit_tracker

Overview:
- Parametrised shadow pipeline that runs alongside the pipelined RV32I core and produces complete RVFI retirement packets.
- Supplies the fields that are not available at WB: inst, rs1_rdata, rs2_rdata, mem_wdata, pc_wdata and order.
- Captures the instruction word and PC at decode, injects late fields at configurable stage indices, and retires in step with WB.
- Holds each retired instruction until the next real retirement, so pc_wdata is the true next PC rather than a hardware-inserted bubble.

Parameters:
- XLEN, 32, datapath / register / address width.
- DEPTH, 4, number of tracked slots; slot 0 = EX, slot DEPTH-1 = WB.
- RS_IDX, 0, slot whose instruction's forwarded rs1/rs2 values are sampled (EX).
- MEMW_IDX, 1, slot whose store data and masks are sampled (MEM).
- ORDER_W, 64, width of the retirement order counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- advance  in  1  whole pipeline shifts this cycle (low = global stall)
- flush_mask  in  DEPTH  per-slot kill (branch redirect)
- id_valid  in  1  a real instruction leaves ID on advance
- id_inst  in  32  instruction word leaving ID
- id_pc  in  XLEN  PC of that instruction
- ex_rs1_rdata, ex_rs2_rdata  in  XLEN each  forwarded operand values of slot RS_IDX
- mem_wdata  in  XLEN  store data of slot MEMW_IDX
- mem_wmask, mem_rmask  in  4 each  byte masks of slot MEMW_IDX
- mem_addr  in  XLEN  data address of slot MEMW_IDX
- wb_rd_addr  in  5  destination register of the WB slot
- wb_rd_wdata  in  XLEN  regfile write data
- wb_load_regfile  in  1  WB writes the regfile
- wb_mem_rdata  in  XLEN  load data of the WB slot
- wb_halt  in  1  WB instruction is a self-targeting br/jal/jalr
- rvfi_valid  out  1  one-cycle commit pulse
- rvfi_order  out  ORDER_W  order of this commit
- rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_wdata, rvfi_mem_rdata  out  32/XLEN  packet fields
- rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  out  5 each  register ids
- rvfi_mem_rmask, rvfi_mem_wmask  out  4 each  byte masks
- rvfi_halt  out  1  asserted with the final commit

Behaviour:
- Reset: all slot valids 0, hold buffer empty, halted=0, halt_pending=0, order=0. All outputs 0 (rvfi_valid=0, rvfi_halt=0) on the cycle after rst is sampled high. Reset mid-operation discards everything in flight.
- rs1_addr and rs2_addr are decoded from inst[19:15] and inst[24:20].
  - Each is forced to 0 for opcodes without that source (lui, auipc, jal; rs2 also for imm, load, jalr).
  - The matching rdata field is forced to 0 whenever its addr is 0.
- Advance = 1:
  - slot0 <= {id_valid & ~flush_mask[0], id_inst, id_pc}.
  - For each i in 0..DEPTH-2: slot[i+1] <= slot[i], with valid &= ~flush_mask[i].
  - Entering from RS_IDX, the packet takes ex_rs*_rdata.
  - Entering from MEMW_IDX, it takes mem_wdata, mem_addr (word-aligned, [1:0]=0) and the masks.
- Advance = 0: slots hold; flush_mask[i] clears slot[i].valid in place.
- Retire event R: advance & slot[DEPTH-1].valid & ~flush_mask[DEPTH-1] & ~halted. R takes its WB fields from the wb_* inputs in that cycle.
- On R:
  - If hold is valid, register an output with the hold packet, pc_wdata = R.pc and order = counter; the counter increments.
  - In all cases hold <= R.
  - Output latency is 1 cycle after R.
- rd_wdata is reported as 0 when wb_load_regfile=0 or rd=0.
- Halt (R with wb_halt=1): any older hold is emitted as above; set halt_pending.
  - Next cycle: emit the hold with pc_wdata = its own pc_rdata, rvfi_halt=1, and its order.
  - Then halted=1 (sticky); further retires are ignored until reset.
- Flush and advance in the same cycle: flush applies to the source slot, so a killed slot moves as a bubble. A flush of slot DEPTH-1 suppresses retirement.
- Order counter wraps modulo 2^ORDER_W.
- Bubbles never reach the hold buffer and never affect pc_wdata.

Decomposition:
- Package rvfi_trk_pkg:
  - rvfi_slot_t struct: valid, inst, pc, rs rdata, mem fields.
  - rvfi_pkt_t output struct.
  - Opcode constants reused from rv32i_types.
- One sub-module, rvfi_slot_pipe: the DEPTH-slot shift register with flush and field injection. The top holds the hold buffer, halt FSM (RUN, HALT_PEND, HALTED), order counter and output registers.

Test Plan:
- Three back-to-back addi at pc 0x60, 0x64, 0x68 then nop at 0x6C, no stalls -> commits for 0x60/0x64/0x68 with pc_wdata 0x64/0x68/0x6C and order 0, 1, 2, each one cycle after the following instruction's retire.
- advance low for 5 cycles while slot DEPTH-1 is valid -> no rvfi_valid during the stall; the packet is emitted only after the next real retire, with unchanged fields.
- Taken beq at 0x80 to 0x100 with flush_mask=4'b0011 -> the 0x84/0x88 entries never commit; the beq commit has pc_wdata=0x100.
- sw x2,4(x1) with x1=0x200 and forwarded x2=0xDEADBEEF -> rvfi_mem_addr=0x204, wmask=4'hF, mem_wdata=0xDEADBEEF, rs2_rdata=0xDEADBEEF, rd_addr=0.
- jal x0,0 at 0xF0 with wb_halt=1 -> previous instruction commits with pc_wdata=0xF0; next cycle the jal commits with pc_wdata=0xF0 and rvfi_halt=1; later retires are ignored.
- rst asserted with two valid slots and a hold pending -> next cycle all outputs 0, order restarts at 0 on the following commit.

Source files
------------

// File: rtl/rvfi_trk_pkg.sv
// Shared types for the RVFI commit tracker: slot and packet layouts, halt FSM
// states, and the RV32I opcodes needed to decide which source registers exist.
package rvfi_trk_pkg;

    localparam int TRK_XLEN = 32;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT_PEND,
        ST_HALTED
    } halt_state_e;

    typedef struct packed {
        logic                valid;
        logic [31:0]         inst;
        logic [TRK_XLEN-1:0] pc;
        logic [TRK_XLEN-1:0] rs1_rdata;
        logic [TRK_XLEN-1:0] rs2_rdata;
        logic [TRK_XLEN-1:0] mem_wdata;
        logic [TRK_XLEN-1:0] mem_addr;
        logic [3:0]          mem_wmask;
        logic [3:0]          mem_rmask;
    } rvfi_slot_t;

    typedef struct packed {
        logic [31:0]         inst;
        logic [TRK_XLEN-1:0] pc_rdata;
        logic [4:0]          rs1_addr;
        logic [4:0]          rs2_addr;
        logic [TRK_XLEN-1:0] rs1_rdata;
        logic [TRK_XLEN-1:0] rs2_rdata;
        logic [4:0]          rd_addr;
        logic [TRK_XLEN-1:0] rd_wdata;
        logic [TRK_XLEN-1:0] mem_addr;
        logic [3:0]          mem_rmask;
        logic [3:0]          mem_wmask;
        logic [TRK_XLEN-1:0] mem_wdata;
        logic [TRK_XLEN-1:0] mem_rdata;
    } rvfi_pkt_t;

    function automatic logic has_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic has_rs2(input logic [6:0] op);
        return has_rs1(op) && !(op == OP_IMM || op == OP_LOAD || op == OP_JALR);
    endfunction

endpackage

// File: rtl/rvfi_slot_pipe.sv
// DEPTH-slot shadow of the core pipeline (slot 0 = EX, last slot = WB); picks up
// operand values and store data as instructions pass the stages that know them.
module rvfi_slot_pipe
    import rvfi_trk_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int RS_IDX   = 0,
    parameter int MEMW_IDX = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic [DEPTH-1:0] flush_mask,
    input  logic             id_valid,
    input  logic [31:0]      id_inst,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  ex_rs1_rdata,
    input  logic [XLEN-1:0]  ex_rs2_rdata,
    input  logic [XLEN-1:0]  mem_wdata,
    input  logic [XLEN-1:0]  mem_addr,
    input  logic [3:0]       mem_wmask,
    input  logic [3:0]       mem_rmask,
    output rvfi_slot_t       tail
);

    rvfi_slot_t slots     [DEPTH];
    rvfi_slot_t slots_nxt [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slots_nxt[i]       = slots[i];
            slots_nxt[i].valid = slots[i].valid & ~flush_mask[i];
        end
        if (advance) begin
            slots_nxt[0]       = '0;
            slots_nxt[0].valid = id_valid & ~flush_mask[0];
            slots_nxt[0].inst  = id_inst;
            slots_nxt[0].pc    = id_pc;
            // a flushed source slot still shifts, but as a bubble
            for (int i = 1; i < DEPTH; i++) begin
                slots_nxt[i]       = slots[i-1];
                slots_nxt[i].valid = slots[i-1].valid & ~flush_mask[i-1];
                if (i == RS_IDX + 1) begin
                    slots_nxt[i].rs1_rdata = ex_rs1_rdata;
                    slots_nxt[i].rs2_rdata = ex_rs2_rdata;
                end
                if (i == MEMW_IDX + 1) begin
                    slots_nxt[i].mem_wdata = mem_wdata;
                    slots_nxt[i].mem_addr  = mem_addr & {{(XLEN-2){1'b1}}, 2'b00};
                    slots_nxt[i].mem_wmask = mem_wmask;
                    slots_nxt[i].mem_rmask = mem_rmask;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) slots[i] <= '0;
            else     slots[i] <= slots_nxt[i];
        end
    end

    assign tail = slots[DEPTH-1];

endmodule

// File: rtl/rvfi_commit_tracker.sv
// Builds RVFI packets from the shadow pipeline; each retirement is parked until
// the next real one so pc_wdata is the architectural next PC.
//   state        | meaning
//   ST_RUN       | normal operation, retirements accepted
//   ST_HALT_PEND | halting instruction in hold, emit it with rvfi_halt next
//   ST_HALTED    | final commit done, retirements ignored until reset
module rvfi_commit_tracker
    import rvfi_trk_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int RS_IDX   = 0,
    parameter int MEMW_IDX = 1,
    parameter int ORDER_W  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               advance,
    input  logic [DEPTH-1:0]   flush_mask,
    input  logic               id_valid,
    input  logic [31:0]        id_inst,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    ex_rs1_rdata,
    input  logic [XLEN-1:0]    ex_rs2_rdata,
    input  logic [XLEN-1:0]    mem_wdata,
    input  logic [3:0]         mem_wmask,
    input  logic [3:0]         mem_rmask,
    input  logic [XLEN-1:0]    mem_addr,
    input  logic [4:0]         wb_rd_addr,
    input  logic [XLEN-1:0]    wb_rd_wdata,
    input  logic               wb_load_regfile,
    input  logic [XLEN-1:0]    wb_mem_rdata,
    input  logic               wb_halt,
    output logic               rvfi_valid,
    output logic [ORDER_W-1:0] rvfi_order,
    output logic [31:0]        rvfi_inst,
    output logic [XLEN-1:0]    rvfi_pc_rdata,
    output logic [XLEN-1:0]    rvfi_pc_wdata,
    output logic [XLEN-1:0]    rvfi_rs1_rdata,
    output logic [XLEN-1:0]    rvfi_rs2_rdata,
    output logic [XLEN-1:0]    rvfi_rd_wdata,
    output logic [XLEN-1:0]    rvfi_mem_addr,
    output logic [XLEN-1:0]    rvfi_mem_wdata,
    output logic [XLEN-1:0]    rvfi_mem_rdata,
    output logic [4:0]         rvfi_rs1_addr,
    output logic [4:0]         rvfi_rs2_addr,
    output logic [4:0]         rvfi_rd_addr,
    output logic [3:0]         rvfi_mem_rmask,
    output logic [3:0]         rvfi_mem_wmask,
    output logic               rvfi_halt
);

    rvfi_slot_t         tail;
    halt_state_e        state, state_nxt;
    logic               retire;
    rvfi_pkt_t          r_pkt, hold_pkt, out_pkt;
    logic               hold_valid;
    logic [ORDER_W-1:0] order_cnt;

    rvfi_slot_pipe #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RS_IDX(RS_IDX), .MEMW_IDX(MEMW_IDX)
    ) u_pipe (
        .clk(clk), .rst(rst), .advance(advance), .flush_mask(flush_mask),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
        .ex_rs1_rdata(ex_rs1_rdata), .ex_rs2_rdata(ex_rs2_rdata),
        .mem_wdata(mem_wdata), .mem_addr(mem_addr),
        .mem_wmask(mem_wmask), .mem_rmask(mem_rmask),
        .tail(tail)
    );

    assign retire = advance & tail.valid & ~flush_mask[DEPTH-1] & (state == ST_RUN);

    always_comb begin
        r_pkt           = '0;
        r_pkt.inst      = tail.inst;
        r_pkt.pc_rdata  = tail.pc;
        if (has_rs1(tail.inst[6:0])) r_pkt.rs1_addr = tail.inst[19:15];
        if (has_rs2(tail.inst[6:0])) r_pkt.rs2_addr = tail.inst[24:20];
        if (r_pkt.rs1_addr != 5'd0)  r_pkt.rs1_rdata = tail.rs1_rdata;
        if (r_pkt.rs2_addr != 5'd0)  r_pkt.rs2_rdata = tail.rs2_rdata;
        // no regfile write means no architectural destination
        if (wb_load_regfile)         r_pkt.rd_addr = wb_rd_addr;
        if (r_pkt.rd_addr != 5'd0)   r_pkt.rd_wdata = wb_rd_wdata;
        r_pkt.mem_addr  = tail.mem_addr;
        r_pkt.mem_rmask = tail.mem_rmask;
        r_pkt.mem_wmask = tail.mem_wmask;
        r_pkt.mem_wdata = tail.mem_wdata;
        r_pkt.mem_rdata = wb_mem_rdata;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:       if (retire && wb_halt) state_nxt = ST_HALT_PEND;
            ST_HALT_PEND: state_nxt = ST_HALTED;
            default:      state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid    <= 1'b0;
            hold_pkt      <= '0;
            order_cnt     <= '0;
            out_pkt       <= '0;
            rvfi_valid    <= 1'b0;
            rvfi_halt     <= 1'b0;
            rvfi_order    <= '0;
            rvfi_pc_wdata <= '0;
        end else begin
            rvfi_valid <= 1'b0;
            rvfi_halt  <= 1'b0;
            if (retire) begin
                if (hold_valid) begin
                    out_pkt       <= hold_pkt;
                    rvfi_pc_wdata <= r_pkt.pc_rdata;
                    rvfi_order    <= order_cnt;
                    rvfi_valid    <= 1'b1;
                    order_cnt     <= order_cnt + 1'b1;
                end
                hold_pkt   <= r_pkt;
                hold_valid <= 1'b1;
            end else if (state == ST_HALT_PEND) begin
                // a self-targeting jump is its own successor
                out_pkt       <= hold_pkt;
                rvfi_pc_wdata <= hold_pkt.pc_rdata;
                rvfi_order    <= order_cnt;
                rvfi_valid    <= 1'b1;
                rvfi_halt     <= 1'b1;
                order_cnt     <= order_cnt + 1'b1;
                hold_valid    <= 1'b0;
            end
        end
    end

    assign rvfi_inst      = out_pkt.inst;
    assign rvfi_pc_rdata  = out_pkt.pc_rdata;
    assign rvfi_rs1_addr  = out_pkt.rs1_addr;
    assign rvfi_rs2_addr  = out_pkt.rs2_addr;
    assign rvfi_rs1_rdata = out_pkt.rs1_rdata;
    assign rvfi_rs2_rdata = out_pkt.rs2_rdata;
    assign rvfi_rd_addr   = out_pkt.rd_addr;
    assign rvfi_rd_wdata  = out_pkt.rd_wdata;
    assign rvfi_mem_addr  = out_pkt.mem_addr;
    assign rvfi_mem_rmask = out_pkt.mem_rmask;
    assign rvfi_mem_wmask = out_pkt.mem_wmask;
    assign rvfi_mem_wdata = out_pkt.mem_wdata;
    assign rvfi_mem_rdata = out_pkt.mem_rdata;

endmodule

// File: tb/tb_rvfi_commit_tracker.sv
// Directed scenarios plus randomized traffic against a queue-based model of
// instructions flowing to WB, parked, and released by the next retirement.
module tb_rvfi_commit_tracker;

    localparam int DEPTH    = 4;
    localparam int RS_IDX   = 0;
    localparam int MEMW_IDX = 1;

    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] SW   = 32'h0020A223;
    localparam logic [31:0] BEQ  = 32'h08000063;
    localparam logic [31:0] JAL0 = 32'h0000006F;

    logic clk;
    logic rst, advance, id_valid, wb_load_regfile, wb_halt;
    logic [DEPTH-1:0] flush_mask;
    logic [31:0] id_inst, id_pc, ex_rs1_rdata, ex_rs2_rdata, mem_wdata, mem_addr;
    logic [31:0] wb_rd_wdata, wb_mem_rdata;
    logic [3:0]  mem_wmask, mem_rmask;
    logic [4:0]  wb_rd_addr;

    logic        rvfi_valid, rvfi_halt;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata;
    logic [31:0] rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_wdata, rvfi_mem_rdata;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;

    rvfi_commit_tracker #(
        .XLEN(32), .DEPTH(DEPTH), .RS_IDX(RS_IDX), .MEMW_IDX(MEMW_IDX), .ORDER_W(64)
    ) dut (
        .clk(clk), .rst(rst), .advance(advance), .flush_mask(flush_mask),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
        .ex_rs1_rdata(ex_rs1_rdata), .ex_rs2_rdata(ex_rs2_rdata),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rmask(mem_rmask),
        .mem_addr(mem_addr), .wb_rd_addr(wb_rd_addr), .wb_rd_wdata(wb_rd_wdata),
        .wb_load_regfile(wb_load_regfile), .wb_mem_rdata(wb_mem_rdata), .wb_halt(wb_halt),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_inst(rvfi_inst),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
        .rvfi_mem_wdata(rvfi_mem_wdata), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_halt(rvfi_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [31:0] inst, pc, rs1, rs2, wdata, addr;
        logic [3:0]  wm, rm;
    } ent_t;

    typedef struct packed {
        logic [31:0] inst, pc, pc_w, rs1d, rs2d, rdw, maddr, mwd, mrd;
        logic [4:0]  rs1a, rs2a, rda;
        logic [3:0]  rm, wm;
        logic [63:0] order;
        logic        halt;
    } pkt_t;

    ent_t        pipe[$];
    pkt_t        clog[$];
    bit          m_hold_v;
    pkt_t        m_hold, exp_pkt;
    bit          exp_valid, exp_halt, exp_zero;
    int          m_hstate;          // 0 running, 1 halt commit owed, 2 halted
    logic [63:0] m_order;
    int          n_total = 0;
    int          n_pass  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    function automatic pkt_t make_pkt(input ent_t e);
        pkt_t p;
        logic [6:0] op;
        p = '0;
        op = e.inst[6:0];
        p.inst = e.inst;
        p.pc   = e.pc;
        p.rs1a = (op == 7'h37 || op == 7'h17 || op == 7'h6F) ? 5'd0 : e.inst[19:15];
        p.rs2a = (op == 7'h37 || op == 7'h17 || op == 7'h6F ||
                  op == 7'h13 || op == 7'h03 || op == 7'h67) ? 5'd0 : e.inst[24:20];
        p.rs1d  = (p.rs1a == 0) ? 32'd0 : e.rs1;
        p.rs2d  = (p.rs2a == 0) ? 32'd0 : e.rs2;
        p.rda   = wb_load_regfile ? wb_rd_addr : 5'd0;
        p.rdw   = (p.rda == 0) ? 32'd0 : wb_rd_wdata;
        p.maddr = e.addr;
        p.mwd   = e.wdata;
        p.wm    = e.wm;
        p.rm    = e.rm;
        p.mrd   = wb_mem_rdata;
        return p;
    endfunction

    function automatic void emit(input pkt_t p, input logic [31:0] pcw, input bit h);
        exp_pkt       = p;
        exp_pkt.pc_w  = pcw;
        exp_pkt.order = m_order;
        exp_pkt.halt  = h;
        exp_valid     = 1'b1;
        exp_halt      = h;
        m_order       = m_order + 64'd1;
    endfunction

    // Advances the model by one clock using the inputs currently driven.
    function automatic void model_step();
        ent_t e, tail;
        pkt_t r;
        if (rst) begin
            pipe.delete();
            e = '{default: 0};
            for (int i = 0; i < DEPTH; i++) pipe.push_back(e);
            m_hold_v = 0; m_hold = '0; m_hstate = 0; m_order = 0;
            exp_valid = 0; exp_halt = 0; exp_zero = 1; exp_pkt = '0;
            return;
        end
        exp_valid = 0; exp_halt = 0; exp_zero = 0;
        tail = pipe[DEPTH-1];
        if (advance && tail.v && !flush_mask[DEPTH-1] && m_hstate == 0) begin
            r = make_pkt(tail);
            if (m_hold_v) emit(m_hold, tail.pc, 1'b0);
            m_hold = r; m_hold_v = 1;
            if (wb_halt) m_hstate = 1;
        end else if (m_hstate == 1) begin
            emit(m_hold, m_hold.pc, 1'b1);
            m_hold_v = 0; m_hstate = 2;
        end
        for (int i = 0; i < DEPTH; i++) if (flush_mask[i]) pipe[i].v = 0;
        if (advance) begin
            pipe[RS_IDX].rs1   = ex_rs1_rdata;
            pipe[RS_IDX].rs2   = ex_rs2_rdata;
            pipe[MEMW_IDX].wdata = mem_wdata;
            pipe[MEMW_IDX].addr  = mem_addr & ~32'h3;
            pipe[MEMW_IDX].wm    = mem_wmask;
            pipe[MEMW_IDX].rm    = mem_rmask;
            void'(pipe.pop_back());
            e = '{default: 0};
            e.v = id_valid && !flush_mask[0];
            e.inst = id_inst;
            e.pc = id_pc;
            pipe.push_front(e);
        end
    endfunction

    task automatic compare();
        pkt_t a;
        a.inst = rvfi_inst; a.pc = rvfi_pc_rdata; a.pc_w = rvfi_pc_wdata;
        a.rs1d = rvfi_rs1_rdata; a.rs2d = rvfi_rs2_rdata; a.rdw = rvfi_rd_wdata;
        a.maddr = rvfi_mem_addr; a.mwd = rvfi_mem_wdata; a.mrd = rvfi_mem_rdata;
        a.rs1a = rvfi_rs1_addr; a.rs2a = rvfi_rs2_addr; a.rda = rvfi_rd_addr;
        a.rm = rvfi_mem_rmask; a.wm = rvfi_mem_wmask; a.order = rvfi_order; a.halt = rvfi_halt;
        chk("valid", 64'(rvfi_valid), 64'(exp_valid));
        chk("halt", 64'(rvfi_halt), 64'(exp_halt));
        if (exp_valid || exp_zero) begin
            chk("order", a.order, exp_pkt.order);
            chk("inst", 64'(a.inst), 64'(exp_pkt.inst));
            chk("pc_rdata", 64'(a.pc), 64'(exp_pkt.pc));
            chk("pc_wdata", 64'(a.pc_w), 64'(exp_pkt.pc_w));
            chk("rs1_addr", 64'(a.rs1a), 64'(exp_pkt.rs1a));
            chk("rs2_addr", 64'(a.rs2a), 64'(exp_pkt.rs2a));
            chk("rs1_rdata", 64'(a.rs1d), 64'(exp_pkt.rs1d));
            chk("rs2_rdata", 64'(a.rs2d), 64'(exp_pkt.rs2d));
            chk("rd_addr", 64'(a.rda), 64'(exp_pkt.rda));
            chk("rd_wdata", 64'(a.rdw), 64'(exp_pkt.rdw));
            chk("mem_addr", 64'(a.maddr), 64'(exp_pkt.maddr));
            chk("mem_rmask", 64'(a.rm), 64'(exp_pkt.rm));
            chk("mem_wmask", 64'(a.wm), 64'(exp_pkt.wm));
            chk("mem_wdata", 64'(a.mwd), 64'(exp_pkt.mwd));
            chk("mem_rdata", 64'(a.mrd), 64'(exp_pkt.mrd));
        end
        if (rvfi_valid) clog.push_back(a);
    endtask

    task automatic tick(input bit r, input bit adv, input bit idv, input logic [31:0] inst,
                        input logic [31:0] pc, input logic [3:0] fm, input bit hlt);
        rst = r; advance = adv; id_valid = idv; id_inst = inst; id_pc = pc;
        flush_mask = fm; wb_halt = hlt;
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic rand_side();
        ex_rs1_rdata = $urandom; ex_rs2_rdata = $urandom;
        mem_wdata = $urandom; mem_addr = $urandom;
        mem_wmask = 4'($urandom); mem_rmask = 4'($urandom);
        wb_rd_addr = 5'($urandom); wb_rd_wdata = $urandom;
        wb_load_regfile = 1'($urandom); wb_mem_rdata = $urandom;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 8))
            0: w[6:0] = 7'h37;
            1: w[6:0] = 7'h17;
            2: w[6:0] = 7'h6F;
            3: w[6:0] = 7'h67;
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h03;
            6: w[6:0] = 7'h23;
            7: w[6:0] = 7'h13;
            default: w[6:0] = 7'h33;
        endcase
        return w;
    endfunction

    function automatic pkt_t lg(input int i);
        if (i < clog.size()) return clog[i];
        return '0;
    endfunction

    initial begin
        int n0;
        rand_side();

        // back-to-back addi, then a stall with the WB slot occupied
        tick(1, 0, 0, 0, 0, 0, 0);
        clog.delete();
        for (int k = 0; k < 10; k++) begin
            rand_side();
            tick(0, 1, 1, (k < 3) ? ADDI : NOP, 32'h60 + 32'(4 * k), 0, 0);
        end
        chk("addi0_pc_wdata", 64'(lg(0).pc_w), 64'h64);
        chk("addi1_pc_wdata", 64'(lg(1).pc_w), 64'h68);
        chk("addi2_pc_wdata", 64'(lg(2).pc_w), 64'h6C);
        chk("addi2_order", lg(2).order, 64'd2);
        chk("addi0_order", lg(0).order, 64'd0);
        n0 = clog.size();
        for (int k = 0; k < 5; k++) begin
            rand_side();
            tick(0, 0, 1, NOP, 32'h88, 0, 0);
        end
        chk("stall_no_commit", 64'(clog.size()), 64'(n0));
        rand_side();
        tick(0, 1, 1, NOP, 32'h88, 0, 0);
        chk("stall_release_pc", 64'(lg(n0).pc), 64'h74);
        chk("stall_release_pc_wdata", 64'(lg(n0).pc_w), 64'h78);

        // taken branch kills the two younger slots
        tick(1, 0, 0, 0, 0, 0, 0);
        clog.delete();
        for (int k = 0; k < 12; k++) begin
            rand_side();
            if (k < 3)       tick(0, 1, 1, (k == 0) ? BEQ : NOP, 32'h80 + 32'(4 * k), 0, 0);
            else if (k == 3) tick(0, 1, 1, NOP, 32'h8C, 4'b0011, 0);
            else             tick(0, 1, 1, NOP, 32'h100 + 32'(4 * (k - 4)), 0, 0);
        end
        chk("beq_pc", 64'(lg(0).pc), 64'h80);
        chk("beq_pc_wdata", 64'(lg(0).pc_w), 64'h100);
        chk("after_beq_pc", 64'(lg(1).pc), 64'h100);
        chk("after_beq_order", lg(1).order, 64'd1);

        // store with forwarded operands and store data
        tick(1, 0, 0, 0, 0, 0, 0);
        clog.delete();
        for (int k = 0; k < 6; k++) begin
            rand_side();
            if (k == 1) begin ex_rs1_rdata = 32'h200; ex_rs2_rdata = 32'hDEADBEEF; end
            if (k == 2) begin
                mem_wdata = 32'hDEADBEEF; mem_addr = 32'h206; mem_wmask = 4'hF; mem_rmask = 4'h0;
            end
            if (k == 4) begin wb_load_regfile = 0; wb_rd_addr = 0; end
            tick(0, 1, 1, (k == 0) ? SW : NOP, 32'h40 + 32'(4 * k), 0, 0);
        end
        chk("sw_mem_addr", 64'(lg(0).maddr), 64'h204);
        chk("sw_wmask", 64'(lg(0).wm), 64'hF);
        chk("sw_mem_wdata", 64'(lg(0).mwd), 64'hDEADBEEF);
        chk("sw_rs2_rdata", 64'(lg(0).rs2d), 64'hDEADBEEF);
        chk("sw_rs1_rdata", 64'(lg(0).rs1d), 64'h200);
        chk("sw_rd_addr", 64'(lg(0).rda), 64'd0);

        // self-jump halts the tracker
        tick(1, 0, 0, 0, 0, 0, 0);
        clog.delete();
        for (int k = 0; k < 12; k++) begin
            rand_side();
            tick(0, 1, 1, (k == 0) ? ADDI : (k == 1) ? JAL0 : NOP,
                 32'hEC + 32'(4 * k), 0, k == 5);
        end
        chk("halt_commits", 64'(clog.size()), 64'd2);
        chk("pre_halt_pc_wdata", 64'(lg(0).pc_w), 64'hF0);
        chk("pre_halt_flag", 64'(lg(0).halt), 64'd0);
        chk("jal_pc_wdata", 64'(lg(1).pc_w), 64'hF0);
        chk("jal_halt", 64'(lg(1).halt), 64'd1);
        chk("jal_order", lg(1).order, 64'd1);

        // reset with work in flight
        tick(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            rand_side();
            tick(0, 1, 1, NOP, 32'h300 + 32'(4 * k), 0, 0);
        end
        rand_side();
        tick(1, 1, 1, NOP, 32'h318, 0, 0);
        chk("reset_valid", 64'(rvfi_valid), 64'd0);
        chk("reset_order", rvfi_order, 64'd0);
        clog.delete();
        for (int k = 0; k < 6; k++) begin
            rand_side();
            tick(0, 1, 1, NOP, 32'h400 + 32'(4 * k), 0, 0);
        end
        chk("post_reset_pc", 64'(lg(0).pc), 64'h400);
        chk("post_reset_order", lg(0).order, 64'd0);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rand_side();
            tick($urandom_range(0, 249) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) != 0, rand_inst(), $urandom & ~32'h3,
                 ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0,
                 $urandom_range(0, 199) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
